// File: rtl/mips_defs.sv
// mips_defs: shared MIPS opcode constants, fetch state encoding and queue entry type.
package mips_defs;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_JAL   = 6'h03;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_ADDI  = 6'h08;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_SPACE = 2'd1,
        DISCARD    = 2'd2
    } fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } qentry_t;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {instr, pc+4} with flush; head is read straight from storage registers.
module fetch_queue import mips_defs::*; #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] din_instr,
    input  logic [31:0] din_pc4,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc4
);
    qentry_t mem [2];
    logic rd, wr, do_pop;
    assign do_pop = pop && count != 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd     <= 1'b0;
            wr     <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= '{instr: din_instr, pc4: din_pc4};
                wr      <= ~wr;
            end
            if (do_pop)
                rd <= ~rd;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end
    assign head_instr = mem[rd].instr;
    assign head_pc4   = mem[rd].pc4;
    // The request policy guarantees a response always has room.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && count == 2'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and req/ack instruction fetcher feeding decode through a 2-entry queue.
module fetch_unit import mips_defs::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
);
    fetch_state_t state, state_n;
    logic [31:0] pc, pc_n, rpc;
    logic [1:0]  count, count_n;
    logic        acc, pop, push;
    always_comb begin
        rpc     = word_align(redirect_pc);
        acc     = imem_req & imem_ack;
        pop     = id_valid & id_ready;
        count_n = count + 2'd1 - {1'b0, pop};
        push    = 1'b0;
        state_n = state;
        pc_n    = pc;
        case (state)
            FETCH:
                if (redirect) begin
                    // An unanswered request must still be held until its ack arrives.
                    pc_n    = rpc;
                    state_n = (acc || !imem_req) ? FETCH : DISCARD;
                end else if (acc) begin
                    push    = 1'b1;
                    pc_n    = pc + 32'd4;
                    state_n = (count_n < 2'(QDEPTH)) ? FETCH : WAIT_SPACE;
                end
            WAIT_SPACE: begin
                pc_n    = redirect ? rpc : pc;
                state_n = (redirect || pop) ? FETCH : WAIT_SPACE;
            end
            DISCARD: begin
                pc_n    = redirect ? rpc : pc;
                state_n = imem_ack ? FETCH : DISCARD;
            end
            default: state_n = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_req  <= state_n != WAIT_SPACE;
            imem_addr <= (state_n == DISCARD) ? imem_addr : pc_n;
        end
    end
    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .din_instr  (imem_rdata),
        .din_pc4    (pc + 32'd4),
        .count      (count),
        .head_instr (id_instr),
        .head_pc4   (id_pc4)
    );
    assign id_valid  = count != 2'd0;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-order delivery model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr, id_pc4;
    logic [5:0]  id_opcode, id_funct;

    int          tests = 0, fails = 0, delivered = 0, lat = 0, waited = 0;
    logic        pend = 1'b0, after_rdir = 1'b0;
    logic [31:0] pend_addr = '0, exp_pc = '0, w;
    logic        r_rd, r_rdy;
    logic [31:0] r_tgt;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode),
        .id_funct    (id_funct)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[9:2], 24'h5A_3C0F};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check the current outputs, answer memory, drive the next inputs.
    task automatic cycle(input logic rd, input logic [31:0] tgt, input logic rdy);
        if (pend) begin
            check("req_held", {31'b0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, pend_addr);
        end
        if (after_rdir)
            check("flush_valid", {31'b0, id_valid}, 32'd0);
        imem_ack = 1'b0;
        if (imem_req) begin
            if (!pend) waited = 0;
            imem_ack   = waited >= lat;
            imem_rdata = word(imem_addr);
            pend       = !imem_ack;
            pend_addr  = imem_addr;
            waited++;
        end else begin
            pend = 1'b0;
        end
        redirect    = rd;
        redirect_pc = tgt;
        id_ready    = rdy;
        if (id_valid && id_ready) begin
            w = word(exp_pc);
            check("instr", id_instr, w);
            check("pc4", id_pc4, exp_pc + 32'd4);
            check("opcode", {26'b0, id_opcode}, {26'b0, w[31:26]});
            check("funct", {26'b0, id_funct}, {26'b0, w[5:0]});
            exp_pc += 32'd4;
            delivered++;
        end
        if (rd) exp_pc = tgt & ~32'd3;
        after_rdir = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        pend = 1'b0;
        after_rdir = 1'b0;
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("start_req", {31'b0, imem_req}, 32'd1);
        check("start_addr", imem_addr, 32'h0);
    endtask

    initial begin
        // Reset state and instruction/pc4 clearing.
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);

        // Streaming at one instruction per cycle.
        lat = 0;
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        check("s_addr1", imem_addr, 32'h4);
        check("s_pc4_1", id_pc4, 32'h4);
        w = word(32'h0);
        check("s_opc1", {26'b0, id_opcode}, {26'b0, w[31:26]});
        cycle(1'b0, 32'h0, 1'b1);
        check("s_addr2", imem_addr, 32'h8);
        check("s_pc4_2", id_pc4, 32'h8);
        cycle(1'b0, 32'h0, 1'b1);
        check("s_addr3", imem_addr, 32'hC);
        check("s_pc4_3", id_pc4, 32'hC);

        // Backpressure fills the queue and stalls requests.
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("bp_req", {31'b0, imem_req}, 32'd0);
        check("bp_valid", {31'b0, id_valid}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_req2", {31'b0, imem_req}, 32'd1);
        check("bp_addr", imem_addr, 32'h8);

        // Redirect while a slow response is in flight.
        lat = 2;
        do_reset();
        cycle(1'b1, 32'h100, 1'b1);
        check("if_addr1", imem_addr, 32'h0);
        check("if_req1", {31'b0, imem_req}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("if_addr2", imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("if_addr3", imem_addr, 32'h100);
        check("if_valid3", {31'b0, id_valid}, 32'd0);
        repeat (2) begin
            cycle(1'b0, 32'h0, 1'b0);
            check("if_wait", {31'b0, id_valid}, 32'd0);
        end
        cycle(1'b0, 32'h0, 1'b0);
        check("if_valid", {31'b0, id_valid}, 32'd1);
        check("if_pc4", id_pc4, 32'h104);

        // Redirect coinciding with an ack that would fill the queue.
        lat = 0;
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h200, 1'b0);
        check("rf_valid", {31'b0, id_valid}, 32'd0);
        check("rf_req", {31'b0, imem_req}, 32'd1);
        check("rf_addr", imem_addr, 32'h200);

        // Wrap-around and target alignment.
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        check("wr_addr1", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1);
        check("wr_addr2", imem_addr, 32'h0);
        check("wr_pc4", id_pc4, 32'h0);
        cycle(1'b1, 32'h103, 1'b1);
        check("al_addr", imem_addr, 32'h100);

        // Randomized traffic; each round's reset lands mid-activity.
        for (int r = 0; r < 8; r++) begin
            lat = $urandom_range(0, 3);
            do_reset();
            delivered = 0;
            for (int c = 0; c < 300; c++) begin
                r_rd  = $urandom_range(0, 15) == 0;
                r_tgt = $urandom_range(0, 1) ? $urandom : {20'h0, 12'($urandom)};
                r_rdy = $urandom_range(0, 3) != 0;
                cycle(r_rd, r_tgt, r_rdy);
            end
            check("progress", {31'b0, delivered > 0}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
